// File: rtl/quant_scale_bias.sv
// Purpose : per-channel requantisation of 8-lane int32 accumulator beats to int8 (scale, round-shift, bias, saturate).
// Latency : 2 cycles; a beat accepted at edge t appears on mData after edge t+1; 1 beat/cycle sustained.
// Backpr. : full valid/ready; S1 stalls behind a held S2, and sData_ready drops only when S1 cannot advance.
//
// Ports:
//   clk, reset (async, active low), start (level enable; low blocks input and zeroes counters)
//   sData_valid/sData_ready/sData_payload : input accumulator beats, lane i = [32i+31:32i]
//   mData_valid/mData_ready/mData_payload/mLast : output int8 beats, lane i = [8i+7:8i]
//   Channel_Num, Total_Beats, Shift : frame geometry and requantisation shift
//   Scale_Read_Addr/Bias_Read_Addr, Scale_In/Bias_In : scale/bias memory with 1-cycle registered read
module quant_scale_bias #(
    parameter int LANES  = 8,
    parameter int ACC_W  = 32,
    parameter int ADDR_W = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   sData_valid,
    output logic                   sData_ready,
    input  logic [LANES*ACC_W-1:0] sData_payload,
    output logic                   mData_valid,
    input  logic                   mData_ready,
    output logic [LANES*8-1:0]     mData_payload,
    output logic                   mLast,
    input  logic [15:0]            Channel_Num,
    input  logic [31:0]            Total_Beats,
    input  logic [4:0]             Shift,
    output logic [ADDR_W-1:0]      Scale_Read_Addr,
    output logic [ADDR_W-1:0]      Bias_Read_Addr,
    input  logic [7:0]             Scale_In,
    input  logic [7:0]             Bias_In
);

    // acc (ACC_W) times a zero-extended 8-bit scale (9 bits signed) needs ACC_W+9 bits;
    // rounding and bias add cannot overflow this width for any legal input.
    localparam int PROD_W = ACC_W + 9;
    localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'(127);
    localparam logic signed [PROD_W-1:0] SAT_MIN = -PROD_W'(128);

    function automatic logic [7:0] requant(
        input logic signed [ACC_W-1:0] acc,
        input logic        [7:0]       scale,
        input logic signed [7:0]       bias,
        input logic        [4:0]       sh
    );
        logic signed [PROD_W-1:0] prod;
        logic signed [PROD_W-1:0] rnd;
        logic signed [PROD_W-1:0] sum;
        prod = acc * $signed({1'b0, scale});
        // round half up: add half an output LSB before the arithmetic shift
        rnd = '0;
        if (sh != 5'd0) begin
            rnd[sh - 5'd1] = 1'b1;
        end
        sum = (prod + rnd) >>> sh;
        sum = sum + PROD_W'(bias);
        if (sum > SAT_MAX) begin
            return 8'h7F;
        end else if (sum < SAT_MIN) begin
            return 8'h80;
        end
        return sum[7:0];
    endfunction

    logic [15:0]            r_chan_cnt;
    logic [31:0]            r_beat_cnt;

    logic                   r_s1_vld;
    logic [LANES*ACC_W-1:0] r_s1_acc;
    logic [ADDR_W-1:0]      r_s1_chan;
    logic                   r_s1_last;

    logic                   r_s2_vld;
    logic [LANES*8-1:0]     r_s2_dat;
    logic                   r_s2_last;

    logic                   w_s1_move;
    logic                   w_accept;
    logic                   w_last;
    logic [ADDR_W-1:0]      w_addr;
    logic [LANES*8-1:0]     w_q;

    assign w_s1_move   = r_s1_vld & (~r_s2_vld | mData_ready);
    // reset term keeps ready low while reset is held, independent of start
    assign sData_ready = reset & start & (~r_s1_vld | w_s1_move);
    assign w_accept    = sData_valid & sData_ready;
    assign w_last      = (r_beat_cnt == Total_Beats - 32'd1);

    // The memory samples the address at the accept edge so the data is ready the cycle S1 first
    // sits in its register; while S1 waits, its own channel is re-presented so the data stays valid.
    assign w_addr          = w_accept ? r_chan_cnt[ADDR_W-1:0] : r_s1_chan;
    assign Scale_Read_Addr = w_addr;
    assign Bias_Read_Addr  = w_addr;

    assign mData_valid   = r_s2_vld;
    assign mData_payload = r_s2_dat;
    assign mLast         = r_s2_last;

    always_comb begin
        w_q = '0;
        for (int l = 0; l < LANES; l++) begin
            w_q[l*8 +: 8] = requant(r_s1_acc[l*ACC_W +: ACC_W], Scale_In, Bias_In, Shift);
        end
    end

    // channel / beat counters describe the next beat to be accepted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_chan_cnt <= '0;
            r_beat_cnt <= '0;
        end else if (!start) begin
            r_chan_cnt <= '0;
            r_beat_cnt <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_chan_cnt <= '0;
                r_beat_cnt <= '0;
            end else begin
                r_beat_cnt <= r_beat_cnt + 32'd1;
                // >= rather than == so a shrinking Channel_Num cannot strand the counter
                r_chan_cnt <= (r_chan_cnt >= Channel_Num - 16'd1) ? 16'd0 : r_chan_cnt + 16'd1;
            end
        end
    end

    // S1: captured accumulator beat waiting for its scale/bias
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_vld  <= 1'b0;
            r_s1_acc  <= '0;
            r_s1_chan <= '0;
            r_s1_last <= 1'b0;
        end else if (w_accept) begin
            r_s1_vld  <= 1'b1;
            r_s1_acc  <= sData_payload;
            r_s1_chan <= r_chan_cnt[ADDR_W-1:0];
            r_s1_last <= w_last;
        end else if (w_s1_move) begin
            r_s1_vld  <= 1'b0;
        end
    end

    // S2: output register; only loads when empty or draining, so a stalled output holds
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s2_vld  <= 1'b0;
            r_s2_dat  <= '0;
            r_s2_last <= 1'b0;
        end else if (w_s1_move) begin
            r_s2_vld  <= 1'b1;
            r_s2_dat  <= w_q;
            r_s2_last <= r_s1_last;
        end else if (mData_ready) begin
            r_s2_vld  <= 1'b0;
            r_s2_last <= 1'b0;
        end
    end

endmodule

// File: doc/quant_scale_bias.md
Name: quant_scale_bias

Overview:
- Downstream stage of the img2col feeder and systolic array: consumes 8-lane int32 accumulator beats, applies per-output-channel requantisation (unsigned scale, rounding right shift, signed bias, int8 saturation), emits 64-bit int8 beats.
- Scale/bias fetched from an external memory with registered 1-cycle read latency (high byte scale, low byte bias of the shared 16-bit word).
- Two-stage pipeline with full valid/ready backpressure.

Parameters:
- LANES, 8, accumulator lanes per beat; all lanes of a beat belong to one output channel.
- ACC_W, 32, signed accumulator width per lane.
- ADDR_W, 9, scale/bias memory address width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level enable; low forces sData_ready=0 and holds both counters at 0.
- sData_valid  in  1  input beat valid.
- sData_ready  out  1  input beat accepted when valid&&ready.
- sData_payload  in  256  lane i = bits [32i+31:32i], signed.
- mData_valid  out  1  output beat valid.
- mData_ready  in  1  downstream ready.
- mData_payload  out  64  lane i = bits [8i+7:8i], signed int8.
- mLast  out  1  qualifies the final beat of a frame.
- Channel_Num  in  16  output channels per cycle of the channel counter (≥1).
- Total_Beats  in  32  beats per frame (≥1).
- Shift  in  5  right-shift amount, 0..31.
- Scale_Read_Addr  out  ADDR_W  scale address.
- Bias_Read_Addr  out  ADDR_W  bias address, always equal to Scale_Read_Addr.
- Scale_In  in  8  unsigned scale; valid one cycle after its address is sampled.
- Bias_In  in  8  signed bias; same timing as Scale_In.

Behaviour:
- Reset (reset=0, asynchronous) clears:
  - S1/S2 valid bits, chan_cnt, beat_cnt;
  - outputs mData_valid=0, mData_payload=0, mLast=0, sData_ready=0, addresses=0.
- Reset asserted mid-frame discards in-flight beats. After release, the first accepted beat is channel 0, beat 0.
- Counters:
  - chan_cnt is the channel of the next beat; it increments on accept and wraps to 0 after Channel_Num-1.
  - beat_cnt increments on accept. The beat accepted with beat_cnt==Total_Beats-1 carries last=1, and both counters clear to 0 on that accept.
  - If a wrap and last coincide, clear wins (same result).
- Read address, combinational:
  - addr = chan_cnt when an accept happens this cycle;
  - otherwise addr = S1.chan.
  - A stalled S1 therefore holds its address, and Scale_In/Bias_In stay valid for it.
- Pipeline:
  - S1 loads {acc lanes, chan, last} on accept.
  - S1 moves to S2 at an edge iff S1 valid && (!S2 valid || mData_ready). The requantised result is computed using Scale_In/Bias_In present in that cycle (always ≥1 cycle after S1's address was sampled).
  - S2 is the output register. mData_valid = S2 valid. S2 clears when handshaked with no S1 moving in.
  - sData_ready = start && (!S1 valid || S1 moves this cycle).
  - Full throughput of 1 beat/cycle with mData_ready held high.
  - Latency: a beat accepted at edge t is presented on mData after edge t+1.
- Output stability: while mData_valid && !mData_ready, payload and mLast hold.
- Arithmetic, per lane:
  - p = acc × {0,scale}, signed, 41 bits.
  - If Shift>0, add 2^(Shift-1).
  - Arithmetic shift right by Shift.
  - Add sign-extended bias.
  - Saturate to [-128,127].
  - No intermediate truncation before saturation.
- Simultaneous accept and output handshake in one cycle: allowed, no bubble.
- start deasserted mid-frame: no new accepts; beats already in S1/S2 drain normally.

Test Plan:
- Reset release, start=1, mData_ready=1; scale=1, bias=0, Shift=0, lanes acc=0..7 -> after edge t+1 mData_payload lanes = 0..7, mData_valid=1.
- Rounding and saturation: acc=300, scale=2, Shift=2, bias=-5 -> (600+2)>>2 = 150, +(-5) = 145, saturated to 127. Then acc=-1000, scale=1, Shift=0, bias=0 -> -128.
- Channel wrap and address: Channel_Num=3, 7 beats, memory word n = {scale n+1, bias 0} -> Scale_Read_Addr sequence 0,1,2,0,1,2,0; lane value acc=10 yields 10,20,30,10,20,30,10.
- Backpressure: mData_ready low for 5 cycles mid-stream -> sData_ready drops after S1 fills. No beat is lost or duplicated, output order is preserved, and payload is stable while stalled.
- mLast: Total_Beats=4 over two frames -> mLast on beats 4 and 8 only. chan_cnt restarts at 0 at frame 2.
- Reset mid-frame with S1 and S2 full -> mData_valid=0 immediately. The next frame's first output uses address 0.
